// File: rtl/fp_mul_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: FSM encoding,
// IEEE754 single-precision constants and a small sizing helper.
package fp_mul_arbiter_pkg;

  localparam int FP_WIDTH = 32;
  localparam logic [FP_WIDTH-1:0] FP_QNAN = 32'h7FC0_0000;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fp_mul_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping from N-1 back to 0.
module rr_arbiter
  import fp_mul_arbiter_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = id_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            any
);

  int idx;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    idx      = 0;
    any      = |req;
    // Scan from the farthest slot back towards ptr so the nearest requester wins.
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx[ID_W-1:0]]) grant_id = idx[ID_W-1:0];
    end
    if (any) grant[grant_id] = 1'b1;
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one IEEE754 single-precision multiplier between N_REQ requesters,
// one operation in flight, round-robin, with a done timeout.
module fp_mul_arbiter
  import fp_mul_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = FP_WIDTH,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_op1,
  input  logic [N_REQ*WIDTH-1:0] req_op2,
  output logic [N_REQ-1:0]       req_ack,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_res,
  output logic                   rsp_err,
  output logic                   mul_ready,
  output logic [WIDTH-1:0]       mul_op1,
  output logic [WIDTH-1:0]       mul_op2,
  input  logic [WIDTH-1:0]       mul_res,
  input  logic                   mul_done
);

  localparam int ID_W = id_width(N_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

  state_t            state, state_next;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   owner;
  logic [N_REQ-1:0]  owner_oh;
  logic [CNT_W-1:0]  cnt;

  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_id;
  logic              grant_any;
  logic [WIDTH-1:0]  op1_arr [N_REQ];
  logic [WIDTH-1:0]  op2_arr [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign op1_arr[k] = req_op1[k*WIDTH +: WIDTH];
    assign op2_arr[k] = req_op2[k*WIDTH +: WIDTH];
  end

  rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_rr (
    .req      (req_valid),
    .ptr      (ptr),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (grant_any)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (grant_any) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (mul_done || cnt == CNT_LAST) state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ack   = '0;
    rsp_valid = '0;
    mul_ready = 1'b0;
    if (state == ST_ISSUE) begin
      req_ack   = owner_oh;
      mul_ready = 1'b1;
    end
    if (state == ST_RESP) rsp_valid = owner_oh;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      owner    <= '0;
      owner_oh <= '0;
      cnt      <= '0;
      mul_op1  <= '0;
      mul_op2  <= '0;
      rsp_res  <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            owner    <= grant_id;
            owner_oh <= grant;
            mul_op1  <= op1_arr[grant_id];
            mul_op2  <= op2_arr[grant_id];
          end
        end
        ST_ISSUE: begin
          ptr <= (owner == ID_LAST) ? '0 : owner + 1'b1;
          cnt <= '0;
        end
        ST_WAIT: begin
          // A completion in the final timeout cycle still counts as success.
          if (mul_done) begin
            rsp_res <= mul_res;
            rsp_err <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            rsp_res <= WIDTH'(FP_QNAN);
            rsp_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a behavioural multiplier of
// programmable latency (0 = never completes).
module tb_fp_mul_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 8;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_op1, req_op2;
  logic [N-1:0]    req_ack, rsp_valid;
  logic [W-1:0]    rsp_res;
  logic            rsp_err;
  logic            mul_ready;
  logic [W-1:0]    mul_op1, mul_op2;
  logic [W-1:0]    mul_res;
  logic            mul_done;

  logic [W-1:0]    op1_q [N];
  logic [W-1:0]    op2_q [N];

  int              vectors = 0;
  int              miscompares = 0;

  // Behavioural multiplier state
  int              lat_sel = 0;
  int              rem = 0;
  logic            m_done = 1'b0;
  logic [W-1:0]    m_res = '0;
  logic [W-1:0]    ma = '0, mb = '0;
  logic            spur = 1'b0;

  fp_mul_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op1   (req_op1),
    .req_op2   (req_op2),
    .req_ack   (req_ack),
    .rsp_valid (rsp_valid),
    .rsp_res   (rsp_res),
    .rsp_err   (rsp_err),
    .mul_ready (mul_ready),
    .mul_op1   (mul_op1),
    .mul_op2   (mul_op2),
    .mul_res   (mul_res),
    .mul_done  (mul_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      req_op1[k*W +: W] = op1_q[k];
      req_op2[k*W +: W] = op2_q[k];
    end
  end

  assign mul_done = m_done | spur;
  assign mul_res  = spur ? 32'h1234_5678 : m_res;

  // Hand-computed IEEE754 products for the operand pairs used below.
  function automatic logic [31:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h4182_0000, 32'h4110_0000}: return 32'h4312_4000; // 16.25 * 9.0
      {32'h3F80_0000, 32'h4000_0000}: return 32'h4000_0000; // 1 * 2
      {32'h4000_0000, 32'h4040_0000}: return 32'h40C0_0000; // 2 * 3
      {32'h4040_0000, 32'h4080_0000}: return 32'h4140_0000; // 3 * 4
      {32'h4080_0000, 32'h40A0_0000}: return 32'h41A0_0000; // 4 * 5
      {32'h3F80_0000, 32'h3F80_0000}: return 32'h3F80_0000; // 1 * 1
      {32'hFF80_0000, 32'h0000_0000}: return 32'hFFFF_FFFF; // -inf * 0
      default:                        return 32'hBAD0_BAD0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mul_ready) begin
      rem    <= lat_sel;
      m_done <= 1'b0;
      ma     <= mul_op1;
      mb     <= mul_op2;
    end else if (rem != 0) begin
      rem    <= rem - 1;
      m_done <= (rem == 1);
      if (rem == 1) m_res <= fmul_model(ma, mb);
    end else begin
      m_done <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Waits for requester k's grant and response; checks ack, operands,
  // single mul_ready pulse, response routing, payload and ack-to-rsp cycles.
  task automatic expect_grant(input int k, input logic [31:0] exp_res, input logic exp_err,
                              input logic [N-1:0] drop, input int exp_cyc, input string tag);
    bit got;
    int rdy;
    int cyc;
    got = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (req_ack != '0) begin got = 1; break; end
    end
    check({tag, "_ack_seen"}, 128'(got), 128'(1));
    check({tag, "_ack"}, 128'(req_ack), 128'(4'b0001 << k));
    check({tag, "_op1"}, 128'(mul_op1), 128'(op1_q[k]));
    check({tag, "_op2"}, 128'(mul_op2), 128'(op2_q[k]));
    rdy = mul_ready ? 1 : 0;
    req_valid = req_valid & ~drop;
    got = 0;
    cyc = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      cyc++;
      if (mul_ready) rdy++;
      if (rsp_valid != '0) begin got = 1; break; end
    end
    check({tag, "_rsp_seen"}, 128'(got), 128'(1));
    check({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(4'b0001 << k));
    check({tag, "_rsp_res"}, 128'(rsp_res), 128'(exp_res));
    check({tag, "_rsp_err"}, 128'(rsp_err), 128'(exp_err));
    check({tag, "_ready_pulses"}, 128'(rdy), 128'(1));
    if (exp_cyc > 0) check({tag, "_latency"}, 128'(cyc), 128'(exp_cyc));
  endtask

  typedef struct {
    int          k;
    logic [31:0] op1;
    logic [31:0] op2;
    int          lat;
    logic [31:0] res;
    logic        err;
    int          cyc;
  } vec_t;

  vec_t vecs [6];
  int   quiet;

  initial begin
    // Ack-negedge to rsp-negedge: L+2 when done arrives, TIMEOUT+1 on abort.
    vecs[0] = '{0, 32'h4182_0000, 32'h4110_0000, 4, 32'h4312_4000, 1'b0, 6};
    vecs[1] = '{1, 32'h4000_0000, 32'h4040_0000, 1, 32'h40C0_0000, 1'b0, 3};
    vecs[2] = '{2, 32'h3F80_0000, 32'h3F80_0000, 7, 32'h3F80_0000, 1'b0, 9};
    vecs[3] = '{3, 32'hFF80_0000, 32'h0000_0000, 2, 32'hFFFF_FFFF, 1'b0, 4};
    vecs[4] = '{2, 32'h3F80_0000, 32'h3F80_0000, 0, 32'h7FC0_0000, 1'b1, 9};
    vecs[5] = '{0, 32'h4080_0000, 32'h40A0_0000, 3, 32'h41A0_0000, 1'b0, 5};

    rst = 1'b0;
    req_valid = '0;
    for (int k = 0; k < N; k++) begin op1_q[k] = '0; op2_q[k] = '0; end
    repeat (3) @(negedge clk);
    check("reset_outputs", 128'({req_ack, rsp_valid, rsp_res, rsp_err, mul_ready, mul_op1, mul_op2}), 128'(0));
    rst = 1'b1;
    @(negedge clk);

    // Single operations, including done/timeout tie, pass-through and abort.
    for (int i = 0; i < 6; i++) begin
      lat_sel = vecs[i].lat;
      op1_q[vecs[i].k] = vecs[i].op1;
      op2_q[vecs[i].k] = vecs[i].op2;
      req_valid[vecs[i].k] = 1'b1;
      expect_grant(vecs[i].k, vecs[i].res, vecs[i].err, 4'b0001 << vecs[i].k, vecs[i].cyc, $sformatf("vec%0d", i));
      @(negedge clk);
      check($sformatf("vec%0d_rsp_pulse", i), 128'(rsp_valid), 128'(0));
      check($sformatf("vec%0d_res_hold", i), 128'(rsp_res), 128'(vecs[i].res));
    end

    // Spurious done while idle must not produce a response or capture.
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    quiet = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid != '0 || mul_ready) quiet++;
    end
    check("spurious_done_quiet", 128'(quiet), 128'(0));
    check("spurious_done_res", 128'(rsp_res), 128'(32'h41A0_0000));

    // Contention: all four held; pointer first moved to 0 by a grant to 3.
    op1_q[0] = 32'h3F80_0000; op2_q[0] = 32'h4000_0000;
    op1_q[1] = 32'h4000_0000; op2_q[1] = 32'h4040_0000;
    op1_q[2] = 32'h4040_0000; op2_q[2] = 32'h4080_0000;
    op1_q[3] = 32'h4080_0000; op2_q[3] = 32'h40A0_0000;
    lat_sel = 2;
    req_valid = 4'b1000;
    expect_grant(3, 32'h41A0_0000, 1'b0, 4'b1000, 0, "pre_cont");
    req_valid = 4'b1111;
    expect_grant(0, 32'h4000_0000, 1'b0, 4'b0000, 0, "cont0");
    expect_grant(1, 32'h40C0_0000, 1'b0, 4'b0000, 0, "cont1");
    expect_grant(2, 32'h4140_0000, 1'b0, 4'b0000, 0, "cont2");
    expect_grant(3, 32'h41A0_0000, 1'b0, 4'b0000, 0, "cont3");
    expect_grant(0, 32'h4000_0000, 1'b0, 4'b1111, 0, "cont4");

    // Pointer wrap: after grant 3 and after grant 2, 0101 must pick 0 then 2.
    req_valid = 4'b1000;
    expect_grant(3, 32'h41A0_0000, 1'b0, 4'b1000, 0, "pre_wrap");
    req_valid = 4'b0101;
    expect_grant(0, 32'h4000_0000, 1'b0, 4'b0001, 0, "wrap_a0");
    expect_grant(2, 32'h4140_0000, 1'b0, 4'b0100, 0, "wrap_a2");
    req_valid = 4'b0101;
    expect_grant(0, 32'h4000_0000, 1'b0, 4'b0001, 0, "wrap_b0");
    expect_grant(2, 32'h4140_0000, 1'b0, 4'b0100, 0, "wrap_b2");

    // Reset two cycles after mul_ready drops the op; late done is ignored.
    op1_q[0] = 32'h4182_0000; op2_q[0] = 32'h4110_0000;
    lat_sel = 5;
    req_valid = 4'b0001;
    quiet = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mul_ready) begin quiet = 1; break; end
    end
    check("rst_issue_seen", 128'(quiet), 128'(1));
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_wait_outputs", 128'({req_ack, rsp_valid, rsp_res, rsp_err, mul_ready, mul_op1, mul_op2}), 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    quiet = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid != '0 || mul_ready) quiet++;
    end
    check("rst_no_rsp", 128'(quiet), 128'(0));
    req_valid = 4'b0011;
    expect_grant(0, 32'h4312_4000, 1'b0, 4'b0001, 7, "post_rst0");
    expect_grant(1, 32'h40C0_0000, 1'b0, 4'b0010, 7, "post_rst1");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1, "time limit");
  end

endmodule
